// File: rtl/coin_input_conditioner.sv
// Coin-slot front end: synchronizes and debounces three raw sensors,
// emitting one strobe per accepted coin or a reject on overlap.
module coin_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic rawFive,
  input  logic rawTen,
  input  logic rawTwentyFive,
  output logic fiveCents,
  output logic tenCents,
  output logic twentyFiveCents,
  output logic coinReject,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    EMIT,
    REJECT,
    WAIT_RELEASE
  } state_t;

  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] coin;
  logic [SYNC_STAGES-1:0][2:0] sync;
  logic [2:0] s;
  logic one_hot;
  logic multi;
  logic hit;
  logic other;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0],
               {rawTwentyFive, rawTen, rawFive}};
    end
  end

  assign s       = sync[SYNC_STAGES-1];
  assign multi   = (s & (s - 3'd1)) != 3'd0;
  assign one_hot = (s != 3'd0) && !multi;
  assign hit     = |(s & coin);
  assign other   = |(s & ~coin);

  // Outputs are registered from the next state, so they track state exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= WAIT_RELEASE;
      cnt             <= '0;
      coin            <= '0;
      fiveCents       <= 1'b0;
      tenCents        <= 1'b0;
      twentyFiveCents <= 1'b0;
      coinReject      <= 1'b0;
      busy            <= 1'b1;
    end else begin
      fiveCents       <= 1'b0;
      tenCents        <= 1'b0;
      twentyFiveCents <= 1'b0;
      coinReject      <= 1'b0;
      busy            <= 1'b1;
      unique case (state)
        IDLE: begin
          if (one_hot) begin
            coin  <= s;
            cnt   <= CW'(1);
            state <= QUALIFY;
          end else if (multi) begin
            state      <= REJECT;
            coinReject <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        QUALIFY: begin
          if (!hit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (other) begin
            state      <= REJECT;
            coinReject <= 1'b1;
          end else if (cnt == LAST) begin
            state           <= EMIT;
            fiveCents       <= coin[0];
            tenCents        <= coin[1];
            twentyFiveCents <= coin[2];
          end else if (cnt != CMAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        EMIT, REJECT: begin
          state <= WAIT_RELEASE;
          cnt   <= '0;
        end
        WAIT_RELEASE: begin
          if (s != 3'd0) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt != CMAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= WAIT_RELEASE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed vector bench for coin_input_conditioner.
// Vectors are driven on the falling edge and checked 1ns after the rising edge.
module tb_coin_input_conditioner;

  logic clock;
  logic reset;
  logic rawFive;
  logic rawTen;
  logic rawTwentyFive;
  logic fiveCents;
  logic tenCents;
  logic twentyFiveCents;
  logic coinReject;
  logic busy;

  coin_input_conditioner dut (
    .clock           (clock),
    .reset           (reset),
    .rawFive         (rawFive),
    .rawTen          (rawTen),
    .rawTwentyFive   (rawTwentyFive),
    .fiveCents       (fiveCents),
    .tenCents        (tenCents),
    .twentyFiveCents (twentyFiveCents),
    .coinReject      (coinReject),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected output code: {five, ten, twentyFive, reject, busy}
  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] B = 5'b00001;
  localparam logic [4:0] F = 5'b10001;
  localparam logic [4:0] T = 5'b01001;
  localparam logic [4:0] Q = 5'b00101;
  localparam logic [4:0] J = 5'b00011;

  typedef struct {
    logic       rst;
    logic       r5;
    logic       r10;
    logic       r25;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int failed = 0;
  int viol = 0;
  logic [3:0] prev_strobe = 4'b0;

  task automatic add(input int n, input logic rst, input logic r5,
                     input logic r10, input logic r25,
                     input logic [4:0] e);
    vec_t v;
    v.rst = rst;
    v.r5  = r5;
    v.r10 = r10;
    v.r25 = r25;
    v.exp = e;
    repeat (n) vecs.push_back(v);
  endtask

  function automatic logic [4:0] outs();
    return {fiveCents, tenCents, twentyFiveCents, coinReject, busy};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // At most one strobe per cycle, none high two cycles in a row.
  always @(negedge clock) begin
    logic [3:0] st;
    st = {fiveCents, tenCents, twentyFiveCents, coinReject};
    if ($countones(st) > 1 || (st & prev_strobe) != 4'b0) viol++;
    prev_strobe = st;
  end

  initial begin
    int lat;
    int extra;
    int waited;
    logic [4:0] got;

    reset = 1'b0;
    rawFive = 1'b0;
    rawTen = 1'b0;
    rawTwentyFive = 1'b0;

    // Reset, then release with all inputs low
    add(2, 0, 0, 0, 0, B);
    add(3, 1, 0, 0, 0, B);
    add(2, 1, 0, 0, 0, N);
    // 10c held 8 cycles
    add(2, 1, 0, 1, 0, N);
    add(3, 1, 0, 1, 0, B);
    add(1, 1, 0, 1, 0, T);
    add(2, 1, 0, 1, 0, B);
    add(5, 1, 0, 0, 0, B);
    add(1, 1, 0, 0, 0, N);
    // 5c bounce 2/1/2, gap, then held 6
    add(2, 1, 1, 0, 0, N);
    add(1, 1, 0, 0, 0, B);
    add(1, 1, 1, 0, 0, B);
    add(1, 1, 1, 0, 0, N);
    add(2, 1, 0, 0, 0, B);
    add(1, 1, 0, 0, 0, N);
    add(2, 1, 1, 0, 0, N);
    add(3, 1, 1, 0, 0, B);
    add(1, 1, 1, 0, 0, F);
    add(5, 1, 0, 0, 0, B);
    add(1, 1, 0, 0, 0, N);
    // 25c and 10c on the same edge
    add(2, 1, 0, 1, 1, N);
    add(1, 1, 0, 0, 0, J);
    add(4, 1, 0, 0, 0, B);
    add(1, 1, 0, 0, 0, N);
    // 10c for 3 cycles, then 5c joins
    add(2, 1, 0, 1, 0, N);
    add(1, 1, 0, 1, 0, B);
    add(2, 1, 1, 1, 0, B);
    add(1, 1, 0, 0, 0, J);
    add(4, 1, 0, 0, 0, B);
    add(1, 1, 0, 0, 0, N);
    // 25c interrupted by reset, then a fresh 25c
    add(2, 1, 0, 0, 1, N);
    add(1, 0, 0, 0, 1, B);
    add(6, 1, 0, 0, 1, B);
    add(5, 1, 0, 0, 0, B);
    add(1, 1, 0, 0, 0, N);
    add(2, 1, 0, 0, 1, N);
    add(3, 1, 0, 0, 1, B);
    add(1, 1, 0, 0, 1, Q);
    add(5, 1, 0, 0, 0, B);
    add(1, 1, 0, 0, 0, N);

    foreach (vecs[i]) begin
      @(negedge clock);
      reset = vecs[i].rst;
      rawFive = vecs[i].r5;
      rawTen = vecs[i].r10;
      rawTwentyFive = vecs[i].r25;
      @(posedge clock);
      #1;
      got = outs();
      tests++;
      if (got !== vecs[i].exp) begin
        failed++;
        $display("FAIL vec[%0d]: outs=%b expected %b",
                 i, got, vecs[i].exp);
      end
    end

    // Held 5c: one strobe at latency 5, no repeats
    @(negedge clock);
    rawFive = 1'b1;
    lat = -1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock);
      #1;
      if (fiveCents && lat < 0) lat = c;
    end
    check("held_latency", lat, 5);
    extra = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (fiveCents) extra++;
    end
    check("held_no_repeat", extra, 0);
    check("held_busy", int'(busy), 1);

    // Same-slot re-insertion while waiting for release
    @(negedge clock);
    rawFive = 1'b0;
    repeat (2) @(negedge clock);
    rawFive = 1'b1;
    repeat (3) @(negedge clock);
    rawFive = 1'b0;
    waited = -1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock);
      #1;
      if (fiveCents) extra++;
      if (!busy && waited < 0) waited = c;
    end
    check("reinsert_no_credit", extra, 0);
    check("rearm_after_release", int'(waited >= 0 && waited < 10), 1);

    check("strobe_exclusive", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
